// File: rtl/ws2812_encoder.sv
// ws2812_encoder: serialises 24-bit GRB pixels into the WS2812 one-wire waveform,
// with a one-entry holding buffer and a latch period after the last pixel of a frame.
module ws2812_encoder #(
  parameter int T0H_TICKS   = 8,
  parameter int T1H_TICKS   = 16,
  parameter int BIT_TICKS   = 25,
  parameter int RESET_TICKS = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_tick,
  input  logic [23:0] i_pixel,
  input  logic        i_last,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_dout,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_underrun
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, RST} state_t;
  state_t      state, state_n;
  logic [23:0] buf_pix, buf_pix_n, sh, sh_n;
  logic        buf_last, buf_last_n, buf_valid, buf_valid_n, cur_last, cur_last_n;
  logic [4:0]  bits, bits_n;
  logic [9:0]  cnt, cnt_n, txh;
  logic        wr, ld, under_n, done_n;
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    bits_n      = bits;
    cnt_n       = cnt;
    cur_last_n  = cur_last;
    under_n     = 1'b0;
    done_n      = 1'b0;
    ld          = 1'b0;
    wr          = i_valid && o_ready;
    buf_pix_n   = wr ? i_pixel : buf_pix;
    buf_last_n  = wr ? i_last : buf_last;
    buf_valid_n = wr || buf_valid;
    txh         = sh[23] ? 10'(T1H_TICKS) : 10'(T0H_TICKS);
    if (i_tick) begin
      case (state)
        IDLE: ld = buf_valid;
        HIGH: begin
          cnt_n   = cnt + 10'd1;
          state_n = (cnt == txh - 10'd1) ? LOW : HIGH;
        end
        LOW: begin
          cnt_n = cnt + 10'd1;
          if (cnt == 10'(BIT_TICKS - 1)) begin
            if (bits != 5'd0) begin
              sh_n    = sh << 1;
              bits_n  = bits - 5'd1;
              cnt_n   = '0;
              state_n = HIGH;
            end else if (cur_last) begin
              cnt_n   = '0;
              state_n = RST;
            end else if (buf_valid) begin
              ld = 1'b1;
            end else begin
              under_n = 1'b1;
              state_n = IDLE;
            end
          end
        end
        RST: begin
          cnt_n   = cnt + 10'd1;
          done_n  = cnt == 10'(RESET_TICKS - 1);
          state_n = done_n ? IDLE : RST;
        end
      endcase
    end
    // o_ready is low whenever buf_valid is set, so a load never races a write
    if (ld) begin
      sh_n        = buf_pix;
      cur_last_n  = buf_last;
      bits_n      = 5'd23;
      cnt_n       = '0;
      state_n     = HIGH;
      buf_valid_n = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      buf_pix      <= '0;
      buf_last     <= 1'b0;
      buf_valid    <= 1'b0;
      sh           <= '0;
      bits         <= '0;
      cnt          <= '0;
      cur_last     <= 1'b0;
      o_ready      <= 1'b1;
      o_dout       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state        <= state_n;
      buf_pix      <= buf_pix_n;
      buf_last     <= buf_last_n;
      buf_valid    <= buf_valid_n;
      sh           <= sh_n;
      bits         <= bits_n;
      cnt          <= cnt_n;
      cur_last     <= cur_last_n;
      o_ready      <= !buf_valid_n;
      o_dout       <= state_n == HIGH;
      o_busy       <= state_n != IDLE;
      o_frame_done <= done_n;
      o_underrun   <= under_n;
    end
  end
endmodule

// File: tb/tb_ws2812_encoder.sv
// tb_ws2812_encoder: directed and randomized frames checked against a per-bit
// waveform model built from the pixel values, tick divider and frame rules.
module tb_ws2812_encoder;
  localparam int T0H = 8, T1H = 16, BIT = 25, RSTT = 1000;
  logic        i_clk = 1'b0, i_reset_n = 1'b1, i_tick = 1'b0, i_last = 1'b0, i_valid = 1'b0;
  logic [23:0] i_pixel = '0;
  logic        o_ready, o_dout, o_busy, o_frame_done, o_underrun;
  int          vectors = 0, errors = 0, div = 1, ph = 0, accepted = 0;
  bit          tick_on = 1'b1;
  logic [24:0] src[$];
  logic [4:0]  rec[$];

  ws2812_encoder dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tick(i_tick), .i_pixel(i_pixel),
    .i_last(i_last), .i_valid(i_valid), .o_ready(o_ready), .o_dout(o_dout),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: retire an accepted pixel, record {ready,underrun,done,busy,dout}, drive next inputs
  task automatic cyc();
    bit acc;
    acc = i_valid && o_ready;
    @(posedge i_clk); #1;
    if (acc) begin
      void'(src.pop_front());
      accepted++;
    end
    rec.push_back({o_ready, o_underrun, o_frame_done, o_busy, o_dout});
    ph = (ph + 1) % div;
    i_tick = tick_on && ph == 0;
    i_valid = src.size() > 0;
    {i_last, i_pixel} = i_valid ? src[0] : 25'd0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [23:0] p, input bit l);
    src.push_back({l, p});
    i_valid = 1'b1;
    {i_last, i_pixel} = src[0];
  endtask

  task automatic check_frame(input string tag, input logic [23:0] pix[$], input bit last,
                             input int d, input int exp_s);
    int s, per, fend, total, hi, lead, ones, base, busy_n, done_n, und_n, done_at, und_at, tail;
    bit on;
    s = -1;
    for (int i = 0; i < rec.size(); i++) if (rec[i][0] && s < 0) s = i;
    check({tag, " start"}, 32'(s >= 0), 32'd1);
    if (s < 0) return;
    if (exp_s >= 0) check({tag, " latency"}, s, exp_s);
    per = BIT * d;
    for (int p = 0; p < pix.size(); p++)
      for (int b = 23; b >= 0; b--) begin
        base = s + (p * 24 + 23 - b) * per;
        hi = (pix[p][b] ? T1H : T0H) * d;
        lead = 0;
        ones = 0;
        on = 1'b1;
        for (int k = 0; k < per; k++) begin
          if (rec[base + k][0] && on) lead++;
          else on = 1'b0;
          ones += int'(rec[base + k][0]);
        end
        check($sformatf("%s px%0d bit%0d high", tag, p, b), lead, hi);
        check($sformatf("%s px%0d bit%0d ones", tag, p, b), ones, hi);
      end
    fend = s + pix.size() * 24 * per;
    total = fend - s + (last ? RSTT * d : 0);
    busy_n = 0; done_n = 0; und_n = 0; done_at = -1; und_at = -1; tail = 0;
    for (int i = 0; i < rec.size(); i++) begin
      busy_n += int'(rec[i][1]);
      done_n += int'(rec[i][2]);
      und_n  += int'(rec[i][3]);
      if (rec[i][2] && done_at < 0) done_at = i;
      if (rec[i][3] && und_at < 0) und_at = i;
      if (i >= fend) tail += int'(rec[i][0]);
    end
    check({tag, " busy cycles"}, busy_n, total);
    check({tag, " low after frame"}, tail, 0);
    check({tag, " frame_done count"}, done_n, last ? 1 : 0);
    check({tag, " underrun count"}, und_n, last ? 0 : 1);
    if (last) check({tag, " frame_done time"}, done_at, s + total);
    else check({tag, " underrun time"}, und_at, fend);
  endtask

  initial begin
    logic [23:0] pix[$];
    int n, hold;
    #1 i_reset_n = 1'b0;
    run(3);
    check("reset outputs", {o_dout, o_ready, o_busy, o_frame_done, o_underrun}, 5'b01000);
    i_reset_n = 1'b1;
    run(2);

    rec.delete(); pix = '{24'h800000};
    send(24'h800000, 1'b1);
    run(1700);
    check_frame("single", pix, 1'b1, 1, 1);

    rec.delete(); accepted = 0; pix = '{24'hFFFFFF, 24'h000000, 24'hA5A5A5};
    send(24'hFFFFFF, 1'b0); send(24'h000000, 1'b0); send(24'hA5A5A5, 1'b1);
    run(2900);
    check_frame("stream", pix, 1'b1, 1, 1);
    check("stream accepted", accepted, 3);
    n = 0;
    for (int i = 0; i < rec.size(); i++) if (!rec[i][4] && (i == 0 || rec[i-1][4])) n++;
    check("stream ready drops", n, 3);

    rec.delete(); pix = '{24'h123456};
    send(24'h123456, 1'b0);
    run(700);
    check_frame("underrun", pix, 1'b0, 1, 1);
    check("underrun idle", {o_dout, o_busy}, 2'b00);

    div = 4; ph = 0;
    rec.delete(); pix = '{24'h000001};
    send(24'h000001, 1'b1);
    run(6500);
    check_frame("decim", pix, 1'b1, 4, -1);

    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(1, 3); ph = 0;
      n = $urandom_range(1, 3);
      rec.delete(); pix.delete();
      for (int p = 0; p < n; p++) begin
        pix.push_back(24'($urandom));
        send(pix[p], p == n - 1);
      end
      run((n * 24 * BIT + RSTT) * div + 60);
      check_frame($sformatf("rand%0d", it), pix, 1'b1, div, -1);
    end

    div = 1; ph = 0;
    run(2);
    rec.delete();
    send(24'($urandom), 1'b1);
    hold = 0;
    while (!o_dout && hold < 50) begin cyc(); hold++; end
    check("midbit rise seen", o_dout, 1'b1);
    run(13 * BIT + 3);
    check("midbit high before reset", o_dout, 1'b1);
    #2 i_reset_n = 1'b0;
    #1 check("async reset outputs", {o_dout, o_ready, o_busy}, 3'b010);
    run(2);
    i_reset_n = 1'b1;
    rec.delete(); pix = '{24'($urandom)};
    send(pix[0], 1'b1);
    run(1700);
    check_frame("after reset", pix, 1'b1, 1, 1);

    tick_on = 1'b0; i_tick = 1'b0;
    rec.delete(); pix = '{24'($urandom)};
    send(pix[0], 1'b1);
    run(200);
    n = 0;
    for (int i = 0; i < rec.size(); i++) n += int'(rec[i][0] | rec[i][1]);
    check("gated line quiet", n, 0);
    check("gated buffer full", o_ready, 1'b0);
    tick_on = 1'b1;
    rec.delete();
    run(1700);
    check_frame("gated start", pix, 1'b1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
